// File: rtl/plab3_mem_write_merge_buffer_pkg.sv
// plab3_mem_consts: shared state encoding and line geometry for the store merge buffer.
package plab3_mem_consts;
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam int c_line_words = 4;
  localparam int c_word_nbits = 32;
  localparam int c_wben_nbits = 16;
endpackage

// File: rtl/plab3_mem_write_merge_buffer_if.sv
// plab3_mem_write_merge_buffer_if: store request side and line write side of the merge buffer.
interface plab3_mem_write_merge_buffer_if #(
  parameter int p_addr_nbits = 32,
  parameter int p_data_nbits = 32,
  parameter int p_line_nbits = 128
);
  logic                      in_val;
  logic                      in_rdy;
  logic [p_addr_nbits-1:0]   in_addr;
  logic [p_data_nbits-1:0]   in_data;
  logic                      out_val;
  logic                      out_rdy;
  logic [p_addr_nbits-5:0]   out_addr;
  logic [p_line_nbits-1:0]   out_data;
  logic [p_line_nbits/8-1:0] out_wben;
  logic                      out_sd;
  modport master (output in_val, in_addr, in_data, out_rdy,
                  input  in_rdy, out_val, out_addr, out_data, out_wben, out_sd);
  modport slave  (input  in_val, in_addr, in_data, out_rdy,
                  output in_rdy, out_val, out_addr, out_data, out_wben, out_sd);
endinterface

// File: rtl/plab3_mem_word_merge.sv
// plab3_mem_word_merge: writes one word into its line slot and sets that slot's byte enables.
module plab3_mem_word_merge
  import plab3_mem_consts::*;
(
  input  logic [1:0]                           slot,
  input  logic [c_word_nbits-1:0]              word,
  input  logic [c_line_words*c_word_nbits-1:0] data_old,
  input  logic [c_wben_nbits-1:0]              mask_old,
  output logic [c_line_words*c_word_nbits-1:0] data_new,
  output logic [c_wben_nbits-1:0]              mask_new
);
  for (genvar i = 0; i < c_line_words; i++) begin : g_word
    assign data_new[c_word_nbits*i +: c_word_nbits] = (slot == 2'(i)) ? word : data_old[c_word_nbits*i +: c_word_nbits];
    assign mask_new[4*i +: 4] = (slot == 2'(i)) ? 4'hF : mask_old[4*i +: 4];
  end
endmodule

// File: rtl/plab3_mem_write_merge_buffer.sv
// plab3_mem_write_merge_buffer: single-entry store coalescing buffer emitting whole-line writes.
module plab3_mem_write_merge_buffer
  import plab3_mem_consts::*;
#(
  parameter int p_addr_nbits = 32,
  parameter int p_data_nbits = 32,
  parameter int p_line_nbits = 128,
  parameter int p_timeout    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic sd,
  input  logic flush,
  output logic empty,
  plab3_mem_write_merge_buffer_if.slave bus
);
  localparam int c_tag_nbits = p_addr_nbits - 4;
  logic [1:0]              state_q, state_d;
  logic [c_tag_nbits-1:0]  tag_q, tag_d;
  logic                    sd_q, sd_d;
  logic [p_line_nbits-1:0] data_q, data_d, merged_data;
  logic [c_wben_nbits-1:0] mask_q, mask_d, merged_mask;
  logic [7:0]              timer_q, timer_d;
  logic tag_hit, rdy, acc, fire, go_drain;
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.in_addr[1:0];
  plab3_mem_word_merge merge (
    .slot     (bus.in_addr[3:2]),
    .word     (bus.in_data),
    .data_old (data_q),
    .mask_old (mask_q),
    .data_new (merged_data),
    .mask_new (merged_mask)
  );
  always_comb begin
    tag_hit  = (bus.in_addr[p_addr_nbits-1:4] == tag_q) && (sd == sd_q);
    rdy      = (state_q == EMPTY) || ((state_q == FILL) && tag_hit);
    acc      = bus.in_val && rdy;
    fire     = (state_q == DRAIN) && bus.out_rdy;
    tag_d    = (state_q == EMPTY && acc) ? bus.in_addr[p_addr_nbits-1:4] : tag_q;
    sd_d     = (state_q == EMPTY && acc) ? sd : sd_q;
    data_d   = fire ? '0 : acc ? merged_data : data_q;
    mask_d   = fire ? '0 : acc ? merged_mask : mask_q;
    timer_d  = (acc || state_q != FILL) ? 8'd0 : timer_q + 8'd1;
    // idle expiry compares the incremented count so a lone store drains p_timeout cycles after it arrives
    go_drain = (&mask_d) || (bus.in_val && !tag_hit) || (sd != sd_q) || flush ||
               (!acc && (timer_q + 8'd1 == 8'(p_timeout - 1)));
    state_d  = (state_q == EMPTY) ? (acc ? ((p_timeout == 1) ? DRAIN : FILL) : EMPTY) :
               (state_q == FILL)  ? (go_drain ? DRAIN : FILL) :
               (fire ? EMPTY : DRAIN);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      tag_q   <= '0;
      sd_q    <= 1'b0;
      data_q  <= '0;
      mask_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      sd_q    <= sd_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      timer_q <= timer_d;
    end
  end
  assign bus.in_rdy   = rdy;
  assign bus.out_val  = (state_q == DRAIN);
  assign bus.out_addr = tag_q;
  assign bus.out_data = data_q;
  assign bus.out_wben = mask_q;
  assign bus.out_sd   = sd_q;
  assign empty        = (state_q == EMPTY);
endmodule

// File: tb/tb_plab3_mem_write_merge_buffer.sv
// tb_plab3_mem_write_merge_buffer: directed scenario tasks for the store merge buffer.
module tb_plab3_mem_write_merge_buffer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sd = 1'b0;
  logic flush = 1'b0;
  logic empty;
  int checks = 0;
  int fails = 0;
  plab3_mem_write_merge_buffer_if bus ();
  plab3_mem_write_merge_buffer #(.p_timeout(8)) dut (
    .clk   (clk),
    .reset (reset),
    .sd    (sd),
    .flush (flush),
    .empty (empty),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    bus.out_rdy = 1'b1;
    step();
    bus.out_rdy = 1'b0;
    checks++;
    if (empty !== 1'b1 || bus.out_val !== 1'b0) begin
      fails++;
      $display("FAIL drain_done: empty=%b out_val=%b want empty=1 out_val=0", empty, bus.out_val);
    end
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.in_val = 1'b1;
    bus.in_addr = a;
    bus.in_data = d;
    step();
    bus.in_val = 1'b0;
  endtask
  task automatic test_reset();
    bus.in_val = 1'b0;
    bus.in_addr = '0;
    bus.in_data = '0;
    bus.out_rdy = 1'b0;
    #3;
    checks++;
    if (bus.out_val !== 1'b0 || bus.in_rdy !== 1'b1 || empty !== 1'b1 || bus.out_sd !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: out_val=%b in_rdy=%b empty=%b out_sd=%b want 0 1 1 0", bus.out_val, bus.in_rdy, empty, bus.out_sd);
    end
    checks++;
    if (bus.out_addr !== 28'h0 || bus.out_wben !== 16'h0 || bus.out_data !== 128'h0) begin
      fails++;
      $display("FAIL reset_data: addr=%h wben=%h data=%h want zeros", bus.out_addr, bus.out_wben, bus.out_data);
    end
    @(negedge clk);
    reset = 1'b1;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (empty !== 1'b1 || bus.out_val !== 1'b0) begin
      fails++;
      $display("FAIL flush_empty: empty=%b out_val=%b want 1 0", empty, bus.out_val);
    end
  endtask
  task automatic test_full_line();
    logic rdy_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_val = 1'b1;
      bus.in_addr = 32'h100 + 32'(4 * i);
      bus.in_data = 32'(i + 1);
      #1;
      if (bus.in_rdy !== 1'b1) rdy_ok = 1'b0;
      step();
    end
    bus.in_val = 1'b0;
    checks++;
    if (rdy_ok !== 1'b1) begin
      fails++;
      $display("FAIL full_rdy: in_rdy dropped during same-line stores, want 1");
    end
    checks++;
    if (bus.out_val !== 1'b1 || bus.out_addr !== 28'h010 || bus.out_wben !== 16'hFFFF) begin
      fails++;
      $display("FAIL full_ctrl: out_val=%b addr=%h wben=%h want 1 010 ffff", bus.out_val, bus.out_addr, bus.out_wben);
    end
    checks++;
    if (bus.out_data !== 128'h00000004_00000003_00000002_00000001) begin
      fails++;
      $display("FAIL full_data: data=%h want 00000004000000030000000200000001", bus.out_data);
    end
    drain();
  endtask
  task automatic test_timeout();
    logic early = 1'b0;
    store(32'h204, 32'hAB);
    for (int k = 1; k < 7; k++) begin
      step();
      if (bus.out_val !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      fails++;
      $display("FAIL timeout_early: out_val rose before cycle 8, want 0");
    end
    step();
    checks++;
    if (bus.out_val !== 1'b1 || bus.out_wben !== 16'h00F0 || bus.out_data !== 128'h000000AB_00000000) begin
      fails++;
      $display("FAIL timeout_drain: out_val=%b wben=%h data=%h want 1 00f0 ab<<32", bus.out_val, bus.out_wben, bus.out_data);
    end
    drain();
  endtask
  task automatic test_line_change();
    store(32'h300, 32'h33);
    bus.in_val = 1'b1;
    bus.in_addr = 32'h310;
    bus.in_data = 32'h44;
    #1;
    checks++;
    if (bus.in_rdy !== 1'b0) begin
      fails++;
      $display("FAIL line_rdy: in_rdy=%b want 0", bus.in_rdy);
    end
    step();
    checks++;
    if (bus.out_val !== 1'b1 || bus.out_addr !== 28'h030 || bus.out_wben !== 16'h000F || bus.out_data !== 128'h33) begin
      fails++;
      $display("FAIL line_drain: out_val=%b addr=%h wben=%h data=%h want 1 030 000f 33", bus.out_val, bus.out_addr, bus.out_wben, bus.out_data);
    end
    checks++;
    if (bus.in_rdy !== 1'b0) begin
      fails++;
      $display("FAIL drain_rdy: in_rdy=%b want 0", bus.in_rdy);
    end
    drain();
    checks++;
    if (bus.in_rdy !== 1'b1) begin
      fails++;
      $display("FAIL line_reaccept: in_rdy=%b want 1", bus.in_rdy);
    end
    step();
    bus.in_val = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (bus.out_val !== 1'b1 || bus.out_addr !== 28'h031 || bus.out_wben !== 16'h000F || bus.out_data !== 128'h44) begin
      fails++;
      $display("FAIL line_second: out_val=%b addr=%h wben=%h data=%h want 1 031 000f 44", bus.out_val, bus.out_addr, bus.out_wben, bus.out_data);
    end
    drain();
  endtask
  task automatic test_domain();
    sd = 1'b0;
    store(32'h400, 32'h55);
    sd = 1'b1;
    bus.in_val = 1'b1;
    bus.in_addr = 32'h404;
    bus.in_data = 32'h66;
    #1;
    checks++;
    if (bus.in_rdy !== 1'b0) begin
      fails++;
      $display("FAIL domain_rdy: in_rdy=%b want 0", bus.in_rdy);
    end
    step();
    checks++;
    if (bus.out_val !== 1'b1 || bus.out_sd !== 1'b0 || bus.out_wben !== 16'h000F || bus.out_data !== 128'h55) begin
      fails++;
      $display("FAIL domain_first: out_val=%b sd=%b wben=%h data=%h want 1 0 000f 55", bus.out_val, bus.out_sd, bus.out_wben, bus.out_data);
    end
    drain();
    step();
    bus.in_val = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (bus.out_sd !== 1'b1 || bus.out_wben !== 16'h00F0 || bus.out_data !== 128'h00000066_00000000) begin
      fails++;
      $display("FAIL domain_second: sd=%b wben=%h data=%h want 1 00f0 66<<32", bus.out_sd, bus.out_wben, bus.out_data);
    end
    drain();
    sd = 1'b0;
  endtask
  task automatic test_flush_merge();
    store(32'h500, 32'h11);
    flush = 1'b1;
    store(32'h500, 32'h22);
    flush = 1'b0;
    checks++;
    if (bus.out_val !== 1'b1 || bus.out_wben !== 16'h000F || bus.out_data !== 128'h22 || bus.out_addr !== 28'h050) begin
      fails++;
      $display("FAIL flush_merge: out_val=%b addr=%h wben=%h data=%h want 1 050 000f 22", bus.out_val, bus.out_addr, bus.out_wben, bus.out_data);
    end
    drain();
  endtask
  task automatic test_stall_reset();
    logic stable = 1'b1;
    store(32'h600, 32'h77);
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_val = 1'b1;
    bus.in_addr = 32'h600;
    bus.in_data = 32'h99;
    for (int k = 0; k < 5; k++) begin
      if (bus.out_val !== 1'b1 || bus.in_rdy !== 1'b0 || bus.out_addr !== 28'h060 ||
          bus.out_wben !== 16'h000F || bus.out_data !== 128'h77) stable = 1'b0;
      step();
    end
    bus.in_val = 1'b0;
    checks++;
    if (stable !== 1'b1) begin
      fails++;
      $display("FAIL stall_stable: outputs changed or in_rdy high while stalled, want held line 060/000f/77");
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.out_val !== 1'b0 || empty !== 1'b1) begin
      fails++;
      $display("FAIL async_reset: out_val=%b empty=%b want 0 1", bus.out_val, empty);
    end
    @(negedge clk);
    reset = 1'b1;
    bus.out_rdy = 1'b1;
    step();
    step();
    bus.out_rdy = 1'b0;
    checks++;
    if (bus.out_val !== 1'b0 || bus.out_wben !== 16'h0 || bus.out_data !== 128'h0) begin
      fails++;
      $display("FAIL entry_lost: out_val=%b wben=%h data=%h want 0 0000 0", bus.out_val, bus.out_wben, bus.out_data);
    end
  endtask
  initial begin
    test_reset();
    test_full_line();
    test_timeout();
    test_line_change();
    test_domain();
    test_flush_merge();
    test_stall_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
